mac_pipe: RTL

Pipelined, parametrised multiply-accumulate for the PE datapath: computes the dot product of `CH` activation/weight lanes, adds either an external partial sum or its own running accumulator, and registers the result. It succeeds the single-cycle combinational MAC. It adds a channel count beyond two, a per-beat activation signedness mode, internal accumulation with clear, saturating or wrapping output, sticky overflow, and a pipeline hold. It sits inside each PE between the weight/activation registers and the psum output path.

---
 rtl/mac_pkg.sv | 23 ++
 rtl/mac_lane.sv | 31 +++
 rtl/mac_pipe.sv | 117 +++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the pipelined multiply-accumulate.
//   prod_w  : exact width of one lane product (BW+1 bit activation x BW bit weight)
//   sum_w   : exact width of the CH-lane product sum
//   ext_w   : working width for sum + addend, wide enough that nothing overflows
//   ACT_*   : encodings of the act_signed input
package mac_pkg;

    localparam logic ACT_UNSIGNED = 1'b0;
    localparam logic ACT_SIGNED   = 1'b1;

    function automatic int prod_w(input int bw);
        return 2 * bw + 1;
    endfunction

    function automatic int sum_w(input int bw, input int ch);
        return prod_w(bw) + $clog2(ch);
    endfunction

    function automatic int ext_w(input int bw, input int psum_bw, input int ch);
        return psum_bw + $clog2(ch) + prod_w(bw) + 1;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// mac_lane: one lane of the MAC, combinational.
//   a          in  BW        activation (unsigned or signed per act_signed)
//   b          in  BW        weight, always signed
//   act_signed in  1         ACT_SIGNED sign-extends a, ACT_UNSIGNED zero-extends
//   prod       out 2*BW+1    exact signed product
module mac_lane
    import mac_pkg::*;
#(
    parameter int BW = 4
) (
    input  logic [BW-1:0]         a,
    input  logic [BW-1:0]         b,
    input  logic                  act_signed,
    output logic [prod_w(BW)-1:0] prod
);

    localparam int PW = prod_w(BW);

    logic [BW:0]   a_ext;
    logic [PW-1:0] a_w;
    logic [PW-1:0] b_w;

    assign a_ext = (act_signed == ACT_SIGNED) ? {a[BW-1], a} : {1'b0, a};

    // Both operands are sign-extended to the product width; the low PW bits
    // of the product are then the exact signed result.
    assign a_w  = {{(PW-BW-1){a_ext[BW]}}, a_ext};
    assign b_w  = {{(PW-BW){b[BW-1]}}, b};
    assign prod = a_w * b_w;

endmodule

// File: rtl/mac_pipe.sv
// mac_pipe: two-stage pipelined CH-lane multiply-accumulate.
//   clk, reset_n   clock / async active-low reset
//   in_valid       beat present on a, b, c, act_signed, acc_sel, acc_clr
//   a, b           CH lanes of BW bits (lane i at [i*BW +: BW])
//   c              external signed partial sum
//   act_signed     activation signedness for this beat
//   acc_sel        0: addend is c, 1: addend is the out register
//   acc_clr        with acc_sel=1 the addend is 0; always restarts ovf
//   hold           freezes every pipeline register
//   out            signed result, saturated (SAT=1) or wrapped (SAT=0)
//   out_valid      out holds a new result this cycle
//   ovf            sticky out-of-range flag
module mac_pipe
    import mac_pkg::*;
#(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int CH      = 4,
    parameter int SAT     = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [CH*BW-1:0]     a,
    input  logic [CH*BW-1:0]     b,
    input  logic [PSUM_BW-1:0]   c,
    input  logic                 act_signed,
    input  logic                 acc_sel,
    input  logic                 acc_clr,
    input  logic                 hold,
    output logic [PSUM_BW-1:0]   out,
    output logic                 out_valid,
    output logic                 ovf
);

    localparam int PW = prod_w(BW);
    localparam int EW = ext_w(BW, PSUM_BW, CH);

    localparam logic signed [EW-1:0] MAX_V = {{(EW-PSUM_BW+1){1'b0}}, {(PSUM_BW-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = {{(EW-PSUM_BW+1){1'b1}}, {(PSUM_BW-1){1'b0}}};

    logic [PW-1:0]      prod_d [CH];
    logic [PW-1:0]      prod_q [CH];
    logic [PSUM_BW-1:0] c_q;
    logic               sel_q;
    logic               clr_q;
    logic               v1_q;

    for (genvar i = 0; i < CH; i++) begin : g_lane
        mac_lane #(.BW(BW)) u_lane (
            .a          (a[i*BW +: BW]),
            .b          (b[i*BW +: BW]),
            .act_signed (act_signed),
            .prod       (prod_d[i])
        );
    end

    // Stage 1: lane products and beat controls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) prod_q[i] <= '0;
            c_q   <= '0;
            sel_q <= 1'b0;
            clr_q <= 1'b0;
            v1_q  <= 1'b0;
        end else if (!hold) begin
            v1_q <= in_valid;
            if (in_valid) begin
                prod_q <= prod_d;
                c_q    <= c;
                sel_q  <= acc_sel;
                clr_q  <= acc_clr;
            end
        end
    end

    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] addend;
    logic                 too_hi;
    logic                 too_lo;
    logic [PSUM_BW-1:0]   res;

    // The accumulator is the out register itself, so a chained beat sees the
    // previous beat's result with no bubble.
    always_comb begin
        if (!sel_q)     addend = {{(EW-PSUM_BW){c_q[PSUM_BW-1]}}, c_q};
        else if (clr_q) addend = '0;
        else            addend = {{(EW-PSUM_BW){out[PSUM_BW-1]}}, out};

        sum = addend;
        for (int i = 0; i < CH; i++)
            sum = sum + {{(EW-PW){prod_q[i][PW-1]}}, prod_q[i]};

        too_hi = (sum > MAX_V);
        too_lo = (sum < MIN_V);

        if (SAT != 0 && too_hi)      res = MAX_V[PSUM_BW-1:0];
        else if (SAT != 0 && too_lo) res = MIN_V[PSUM_BW-1:0];
        else                         res = sum[PSUM_BW-1:0];
    end

    // Stage 2: result, valid and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (!hold) begin
            out_valid <= v1_q;
            if (v1_q) begin
                out <= res;
                ovf <= clr_q ? (too_hi | too_lo) : (ovf | too_hi | too_lo);
            end
        end
    end

endmodule
